// File: rtl/skipring_sched.sv
// skipring_sched -- configuration sequencer for a skipring instance.
//
// Holds a DEPTH-entry table of (SEL, MASK, DWELL) entries and applies them to
// the ring in order. Each entry stays active for DWELL ring wraps. A wrap is
// one rising edge of the ring status iST. The sequence can stop after the last
// entry or loop back to entry 0.
//
// Ports
//   iCLK, iRST_N            clock, asynchronous active-low reset
//   iWR/iWADDR/iWSEL/
//   iWMASK/iWDWELL          table write port, accepted in any state
//   iSTART, iSTOP           start (honoured in IDLE only) and abort
//   iLAST, iLOOP            last entry index and loop enable, latched at start
//   iST                     ring status; each rising edge is one wrap
//   oSEL, oMASK, oE, oRST   ring configuration and control (registered)
//   oIDX                    active entry index
//   oBUSY, oDONE            sequencer busy, one-cycle completion pulse
module skipring_sched #(
  parameter  int unsigned LEN     = 16,
  parameter  int unsigned DEPTH   = 4,
  parameter  int unsigned DWELL_W = 16,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               iWR,
  input  logic [AW-1:0]      iWADDR,
  input  logic [LEN-1:0]     iWSEL,
  input  logic [LEN-1:0]     iWMASK,
  input  logic [DWELL_W-1:0] iWDWELL,
  input  logic               iSTART,
  input  logic               iSTOP,
  input  logic [AW-1:0]      iLAST,
  input  logic               iLOOP,
  input  logic               iST,
  output logic [LEN-1:0]     oSEL,
  output logic [LEN-1:0]     oMASK,
  output logic               oE,
  output logic               oRST,
  output logic [AW-1:0]      oIDX,
  output logic               oBUSY,
  output logic               oDONE
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  // Configuration table
  logic [LEN-1:0]     tbl_sel_q   [DEPTH];
  logic [LEN-1:0]     tbl_mask_q  [DEPTH];
  logic [DWELL_W-1:0] tbl_dwell_q [DEPTH];

  logic [1:0]         state_q, state_d;
  logic [AW-1:0]      idx_q,   idx_d;
  logic [AW-1:0]      last_q,  last_d;
  logic               loop_q,  loop_d;
  logic [LEN-1:0]     sel_q,   sel_d;
  logic [LEN-1:0]     mask_q,  mask_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] cnt_q,   cnt_d;
  logic               e_q,     e_d;
  logic               rst_q,   rst_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;
  logic               st_q;

  logic               wrap;
  logic               expire;

  assign wrap = iST & ~st_q;

  // Dwell expires on the wrap that brings the count to DWELL; a DWELL of 0
  // behaves as 1, so any wrap expires it.
  assign expire = (dwell_q <= DWELL_W'(1)) ? 1'b1
                                           : (cnt_q == (dwell_q - DWELL_W'(1)));

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tbl_sel_q[i]   <= '0;
        tbl_mask_q[i]  <= '0;
        tbl_dwell_q[i] <= '0;
      end
    end else if (iWR) begin
      tbl_sel_q[iWADDR]   <= iWSEL;
      tbl_mask_q[iWADDR]  <= iWMASK;
      tbl_dwell_q[iWADDR] <= iWDWELL;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    loop_d  = loop_q;
    sel_d   = sel_q;
    mask_d  = mask_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    e_d     = e_q;
    rst_d   = rst_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        e_d   = 1'b0;
        rst_d = 1'b1;
        if (iSTART) begin
          state_d = S_LOAD;
          idx_d   = '0;
          last_d  = iLAST;
          loop_d  = iLOOP;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        if (iSTOP) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          e_d     = 1'b0;
          rst_d   = 1'b1;
        end else begin
          // Reads the registered table, so a same-cycle write to this
          // address is seen only at the entry's next load.
          sel_d   = tbl_sel_q[idx_q];
          mask_d  = tbl_mask_q[idx_q];
          dwell_d = tbl_dwell_q[idx_q];
          cnt_d   = '0;
          e_d     = 1'b1;
          rst_d   = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (iSTOP) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          e_d     = 1'b0;
          rst_d   = 1'b1;
          cnt_d   = '0;
        end else if (wrap) begin
          if (expire) begin
            cnt_d = '0;
            e_d   = 1'b0;
            rst_d = 1'b1;
            if (idx_q == last_q) begin
              if (loop_q) begin
                idx_d   = '0;
                state_d = S_LOAD;
              end else begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end
            end else begin
              idx_d   = idx_q + AW'(1);
              state_d = S_LOAD;
            end
          end else begin
            cnt_d = cnt_q + DWELL_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        e_d     = 1'b0;
        rst_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      loop_q  <= 1'b0;
      sel_q   <= '0;
      mask_q  <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      e_q     <= 1'b0;
      rst_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      st_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      loop_q  <= loop_d;
      sel_q   <= sel_d;
      mask_q  <= mask_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      e_q     <= e_d;
      rst_q   <= rst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      st_q    <= iST;
    end
  end

  assign oSEL  = sel_q;
  assign oMASK = mask_q;
  assign oE    = e_q;
  assign oRST  = rst_q;
  assign oIDX  = idx_q;
  assign oBUSY = busy_q;
  assign oDONE = done_q;

endmodule
